// File: rtl/fpu_seq.sv
`default_nettype none
// ============================================================================
// Module      : fpu_seq
// Description : Handshaked multi-cycle FP add/sub/mul (truncating, DAZ).
//               The multiplier is an iterative shift-add unit.
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+MAN_W:0]     A,
    input  logic [EXP_W+MAN_W:0]     B,
    input  logic [1:0]               opcode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     outp,
    output logic                     flag_nv,
    output logic                     flag_of,
    output logic                     flag_uf
);
    localparam int c_W  = 1 + EXP_W + MAN_W;
    localparam int c_MW = MAN_W + 1;
    localparam int c_SW = MAN_W + 2;
    localparam int c_PW = 2 * c_MW;
    localparam int c_XW = EXP_W + 2;
    localparam int c_LW = $clog2(c_PW + 1);
    localparam int c_CW = $clog2(c_MW + 1);
    localparam logic signed [c_XW-1:0] c_BIAS = c_XW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [c_XW-1:0] c_EMAX = c_XW'((1 << EXP_W) - 1);
    localparam logic [c_W-1:0] c_CNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE, S_UNPACK, S_ADD, S_MUL, S_NORM, S_PACK, S_DONE
    } state_t;

    state_t                   state_q, state_d;
    logic                     in_ready_q, in_ready_d;
    logic                     out_valid_q, out_valid_d;
    logic [c_W-1:0]           outp_q, outp_d;
    logic                     flag_nv_q, flag_nv_d;
    logic                     flag_of_q, flag_of_d;
    logic                     flag_uf_q, flag_uf_d;
    logic [c_W-1:0]           a_q, a_d, b_q, b_d;
    logic [1:0]               op_q, op_d;
    logic [EXP_W-1:0]         ea_q, ea_d, eb_q, eb_d;
    logic [c_MW-1:0]          ma_q, ma_d, mb_q, mb_d;
    logic                     sa_q, sa_d, sb_q, sb_d;
    logic                     sign_q, sign_d;
    logic                     zsign_q, zsign_d;
    logic                     special_q, special_d;
    logic signed [c_XW-1:0]   exp_q, exp_d;
    logic [c_PW-1:0]          acc_q, acc_d;
    logic [c_PW-1:0]          mcand_q, mcand_d;
    logic [c_MW-1:0]          mplier_q, mplier_d;
    logic [c_CW-1:0]          cnt_q, cnt_d;

    // Operand field decode (reads the registered operands during UNPACK)
    logic [EXP_W-1:0] w_ea, w_eb;
    logic [MAN_W-1:0] w_fa, w_fb;
    logic             w_a_zero, w_b_zero, w_a_nan, w_b_nan, w_a_inf, w_b_inf;
    logic             w_sa, w_sb_eff, w_inf_s;
    logic [c_MW-1:0]  w_ma, w_mb;

    assign w_ea     = a_q[c_W-2 -: EXP_W];
    assign w_eb     = b_q[c_W-2 -: EXP_W];
    assign w_fa     = a_q[MAN_W-1:0];
    assign w_fb     = b_q[MAN_W-1:0];
    assign w_a_zero = (w_ea == '0);
    assign w_b_zero = (w_eb == '0);
    assign w_a_nan  = (&w_ea) && (|w_fa);
    assign w_b_nan  = (&w_eb) && (|w_fb);
    assign w_a_inf  = (&w_ea) && !(|w_fa);
    assign w_b_inf  = (&w_eb) && !(|w_fb);
    assign w_sa     = a_q[c_W-1];
    assign w_sb_eff = b_q[c_W-1] ^ (op_q == 2'b01);
    assign w_inf_s  = op_q[1] ? (w_sa ^ w_sb_eff) : (w_a_inf ? w_sa : w_sb_eff);
    assign w_ma     = w_a_zero ? '0 : {1'b1, w_fa};
    assign w_mb     = w_b_zero ? '0 : {1'b1, w_fb};

    // Alignment: larger magnitude first, smaller shifted right (bits beyond the width vanish)
    logic             w_a_big, w_big_s;
    logic [EXP_W-1:0] w_big_e, w_sml_e, w_diff;
    logic [c_MW-1:0]  w_big_m, w_sml_m;
    logic [c_SW-1:0]  w_sml_sh, w_sum;

    assign w_a_big  = {ea_q, ma_q} >= {eb_q, mb_q};
    assign w_big_e  = w_a_big ? ea_q : eb_q;
    assign w_sml_e  = w_a_big ? eb_q : ea_q;
    assign w_big_m  = w_a_big ? ma_q : mb_q;
    assign w_sml_m  = w_a_big ? mb_q : ma_q;
    assign w_big_s  = w_a_big ? sa_q : sb_q;
    assign w_diff   = w_big_e - w_sml_e;
    assign w_sml_sh = {1'b0, w_sml_m} >> w_diff;
    assign w_sum    = (sa_q == sb_q) ? ({1'b0, w_big_m} + w_sml_sh)
                                     : ({1'b0, w_big_m} - w_sml_sh);

    // Leading zeros of acc[2*MAN_W:0]; bit 2*MAN_W is the normalised hidden-bit slot
    function automatic logic [c_LW-1:0] lzc_f(input logic [c_PW-1:0] v);
        logic [c_LW-1:0] n;
        n = '0;
        for (int i = 0; i < c_PW - 1; i++) begin
            if (v[i]) n = c_LW'(c_PW - 2 - i);
        end
        return n;
    endfunction

    logic [c_LW-1:0] w_lzc;
    assign w_lzc = lzc_f(acc_q);

    always_comb begin
        state_d   = state_q;
        outp_d    = outp_q;
        flag_nv_d = flag_nv_q;
        flag_of_d = flag_of_q;
        flag_uf_d = flag_uf_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        ea_d      = ea_q;
        eb_d      = eb_q;
        ma_d      = ma_q;
        mb_d      = mb_q;
        sa_d      = sa_q;
        sb_d      = sb_q;
        sign_d    = sign_q;
        zsign_d   = zsign_q;
        special_d = special_q;
        exp_d     = exp_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_d       = A;
                    b_d       = B;
                    op_d      = opcode;
                    flag_nv_d = 1'b0;
                    flag_of_d = 1'b0;
                    flag_uf_d = 1'b0;
                    state_d   = S_UNPACK;
                end
            end
            S_UNPACK: begin
                ea_d      = w_ea;
                eb_d      = w_eb;
                ma_d      = w_ma;
                mb_d      = w_mb;
                sa_d      = w_sa;
                sb_d      = w_sb_eff;
                sign_d    = w_sa ^ w_sb_eff;
                // Exact-zero sign: cancellation gives +0, (-0)+(-0) gives -0
                zsign_d   = op_q[1] ? (w_sa ^ w_sb_eff) : (w_sa & w_sb_eff);
                exp_d     = c_XW'(w_ea) + c_XW'(w_eb) - c_BIAS;
                acc_d     = '0;
                mcand_d   = c_PW'(w_ma);
                mplier_d  = w_mb;
                cnt_d     = '0;
                special_d = 1'b1;
                if (op_q == 2'b11) begin
                    outp_d    = c_CNAN;
                    flag_nv_d = 1'b1;
                end else if (w_a_nan || w_b_nan) begin
                    outp_d = c_CNAN;
                end else if (!op_q[1] && w_a_inf && w_b_inf && (w_sa != w_sb_eff)) begin
                    outp_d    = c_CNAN;
                    flag_nv_d = 1'b1;
                end else if (op_q[1] && ((w_a_inf && w_b_zero) || (w_b_inf && w_a_zero))) begin
                    outp_d    = c_CNAN;
                    flag_nv_d = 1'b1;
                end else if (w_a_inf || w_b_inf) begin
                    outp_d = {w_inf_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                end else begin
                    special_d = 1'b0;
                end
                state_d = special_d ? S_PACK : (op_q[1] ? S_MUL : S_ADD);
            end
            S_ADD: begin
                acc_d   = c_PW'(w_sum) << MAN_W;
                exp_d   = c_XW'(w_big_e);
                sign_d  = w_big_s;
                state_d = S_NORM;
            end
            S_MUL: begin
                if (mplier_q[0]) acc_d = acc_q + mcand_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + c_CW'(1);
                if (cnt_q == c_CW'(MAN_W)) state_d = S_NORM;
            end
            S_NORM: begin
                if (acc_q[c_PW-1]) begin
                    acc_d = acc_q >> 1;
                    exp_d = exp_q + c_XW'(1);
                end else begin
                    acc_d = acc_q << w_lzc;
                    exp_d = exp_q - c_XW'(w_lzc);
                end
                state_d = S_PACK;
            end
            S_PACK: begin
                if (!special_q) begin
                    if (acc_q == '0) begin
                        outp_d = {zsign_q, {(c_W-1){1'b0}}};
                    end else if (exp_q >= c_EMAX) begin
                        outp_d    = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                        flag_of_d = 1'b1;
                    end else if (exp_q[c_XW-1] || (exp_q == '0)) begin
                        outp_d    = {sign_q, {(c_W-1){1'b0}}};
                        flag_uf_d = 1'b1;
                    end else begin
                        outp_d = {sign_q, exp_q[EXP_W-1:0], acc_q[2*MAN_W-1 -: MAN_W]};
                    end
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            outp_q      <= '0;
            flag_nv_q   <= 1'b0;
            flag_of_q   <= 1'b0;
            flag_uf_q   <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            ea_q        <= '0;
            eb_q        <= '0;
            ma_q        <= '0;
            mb_q        <= '0;
            sa_q        <= 1'b0;
            sb_q        <= 1'b0;
            sign_q      <= 1'b0;
            zsign_q     <= 1'b0;
            special_q   <= 1'b0;
            exp_q       <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            outp_q      <= outp_d;
            flag_nv_q   <= flag_nv_d;
            flag_of_q   <= flag_of_d;
            flag_uf_q   <= flag_uf_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            ea_q        <= ea_d;
            eb_q        <= eb_d;
            ma_q        <= ma_d;
            mb_q        <= mb_d;
            sa_q        <= sa_d;
            sb_q        <= sb_d;
            sign_q      <= sign_d;
            zsign_q     <= zsign_d;
            special_q   <= special_d;
            exp_q       <= exp_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            cnt_q       <= cnt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign outp      = outp_q;
    assign flag_nv   = flag_nv_q;
    assign flag_of   = flag_of_q;
    assign flag_uf   = flag_uf_q;

endmodule
`default_nettype wire

// File: tb/tb_fpu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpu_seq
// Description : Directed vector bench for fpu_seq (single and half-size builds).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpu_seq;
    typedef struct {
        string       name;
        logic        sel;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [2:0]  fl;
        int          lat;
    } vec_t;

    localparam int c_NV = 22;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        drv_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic [1:0]  opcode = '0;

    logic        in_valid_l, in_valid_s;
    logic        in_ready_l, out_valid_l, nv_l, of_l, uf_l;
    logic        in_ready_s, out_valid_s, nv_s, of_s, uf_s;
    logic [31:0] outp_l;
    logic [15:0] outp_s;
    logic        mon_in_ready, mon_out_valid;
    logic [31:0] mon_outp;
    logic [2:0]  mon_flags;

    int checks   = 0;
    int failures = 0;
    vec_t vecs [c_NV];

    always #5 clk = ~clk;

    assign in_valid_l    = drv_valid & ~sel;
    assign in_valid_s    = drv_valid & sel;
    assign mon_in_ready  = sel ? in_ready_s  : in_ready_l;
    assign mon_out_valid = sel ? out_valid_s : out_valid_l;
    assign mon_outp      = sel ? {16'h0000, outp_s} : outp_l;
    assign mon_flags     = sel ? {nv_s, of_s, uf_s} : {nv_l, of_l, uf_l};

    fpu_seq u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_l), .in_ready(in_ready_l),
        .A(A), .B(B), .opcode(opcode),
        .out_valid(out_valid_l), .out_ready(out_ready),
        .outp(outp_l), .flag_nv(nv_l), .flag_of(of_l), .flag_uf(uf_l)
    );

    fpu_seq #(.EXP_W(5), .MAN_W(10)) u_dut16 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_s), .in_ready(in_ready_s),
        .A(A[15:0]), .B(B[15:0]), .opcode(opcode),
        .out_valid(out_valid_s), .out_ready(out_ready),
        .outp(outp_s), .flag_nv(nv_s), .flag_of(of_s), .flag_uf(uf_s)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp_v);
        end
    endtask

    // Issue one op, measure accept->out_valid latency, check, then take the result.
    task automatic run_vec(input vec_t v);
        int lat;
        int guard;
        sel   = v.sel;
        guard = 0;
        while (!mon_in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        A         = v.a;
        B         = v.b;
        opcode    = v.op;
        drv_valid = 1'b1;
        @(negedge clk);
        drv_valid = 1'b0;
        lat = 0;
        while (!mon_out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk($sformatf("%s latency", v.name), 64'(lat), 64'(v.lat));
        chk($sformatf("%s result", v.name), 64'(mon_outp), 64'(v.res));
        chk($sformatf("%s flags", v.name), 64'(mon_flags), 64'(v.fl));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk($sformatf("%s handshake", v.name), 64'({mon_in_ready, mon_out_valid}), 64'(2'b10));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        //            name          sel   op     a             b             res           fl      lat
        vecs[0]  = '{"add_2_3",     1'b0, 2'b00, 32'h40000000, 32'h40400000, 32'h40A00000, 3'b000, 4};
        vecs[1]  = '{"mul_1p5_2",   1'b0, 2'b10, 32'h3FC00000, 32'h40000000, 32'h40400000, 3'b000, 27};
        vecs[2]  = '{"sub_3_3",     1'b0, 2'b01, 32'h40400000, 32'h40400000, 32'h00000000, 3'b000, 4};
        vecs[3]  = '{"inf_m_inf",   1'b0, 2'b01, 32'h7F800000, 32'h7F800000, 32'h7FC00000, 3'b100, 2};
        vecs[4]  = '{"mul_of",      1'b0, 2'b10, 32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 3'b010, 27};
        vecs[5]  = '{"mul_uf",      1'b0, 2'b10, 32'h00800000, 32'h00800000, 32'h00000000, 3'b001, 27};
        vecs[6]  = '{"nan_in",      1'b0, 2'b00, 32'h7F800001, 32'h3F800000, 32'h7FC00000, 3'b000, 2};
        vecs[7]  = '{"zero_x_inf",  1'b0, 2'b10, 32'h00000000, 32'h7F800000, 32'h7FC00000, 3'b100, 2};
        vecs[8]  = '{"op_11",       1'b0, 2'b11, 32'h3F800000, 32'h3F800000, 32'h7FC00000, 3'b100, 2};
        vecs[9]  = '{"inf_p_1",     1'b0, 2'b00, 32'h7F800000, 32'h3F800000, 32'h7F800000, 3'b000, 2};
        vecs[10] = '{"one_m_inf",   1'b0, 2'b01, 32'h3F800000, 32'h7F800000, 32'hFF800000, 3'b000, 2};
        vecs[11] = '{"nz_p_nz",     1'b0, 2'b00, 32'h80000000, 32'h80000000, 32'h80000000, 3'b000, 4};
        vecs[12] = '{"one_m_0p75",  1'b0, 2'b01, 32'h3F800000, 32'h3F400000, 32'h3E800000, 3'b000, 4};
        vecs[13] = '{"mul_neg",     1'b0, 2'b10, 32'hC0000000, 32'h40400000, 32'hC0C00000, 3'b000, 27};
        vecs[14] = '{"daz",         1'b0, 2'b00, 32'h00400000, 32'h3F800000, 32'h3F800000, 3'b000, 4};
        vecs[15] = '{"mul_trunc",   1'b0, 2'b10, 32'h3F800001, 32'h3F800001, 32'h3F800002, 3'b000, 27};
        vecs[16] = '{"add_of",      1'b0, 2'b00, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 3'b010, 4};
        vecs[17] = '{"mul_nz",      1'b0, 2'b10, 32'h80000000, 32'h40A00000, 32'h80000000, 3'b000, 27};
        vecs[18] = '{"add_far",     1'b0, 2'b00, 32'h4B000000, 32'h3F800000, 32'h4B000001, 3'b000, 4};
        vecs[19] = '{"h_add_2_3",   1'b1, 2'b00, 32'h00004000, 32'h00004200, 32'h00004500, 3'b000, 4};
        vecs[20] = '{"h_op_11",     1'b1, 2'b11, 32'h00004000, 32'h00004200, 32'h00007E00, 3'b100, 2};
        vecs[21] = '{"after_rst",   1'b0, 2'b00, 32'h3F800000, 32'h3F800000, 32'h40000000, 3'b000, 4};

        repeat (3) @(negedge clk);
        chk("reset in_ready", 64'(in_ready_l), 64'd1);
        chk("reset out_valid", 64'(out_valid_l), 64'd0);
        chk("reset outp", 64'(outp_l), 64'd0);
        chk("reset flags", 64'({nv_l, of_l, uf_l}), 64'd0);
        chk("reset h in_ready/out_valid", 64'({in_ready_s, out_valid_s}), 64'(2'b10));
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < c_NV - 1; i++) run_vec(vecs[i]);

        // Backpressure: result, flags held; busy-time in_valid must be ignored
        sel       = 1'b0;
        A         = 32'h40000000;
        B         = 32'h40400000;
        opcode    = 2'b00;
        drv_valid = 1'b1;
        @(negedge clk);
        drv_valid = 1'b0;
        for (int g = 0; g < 50 && !out_valid_l; g++) @(negedge clk);
        A         = 32'h3F800000;
        opcode    = 2'b10;
        drv_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("bp hold %0d", i),
                64'({out_valid_l, in_ready_l, outp_l, nv_l, of_l, uf_l}),
                64'({1'b1, 1'b0, 32'h40A00000, 3'b000}));
        end
        drv_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp release", 64'({in_ready_l, out_valid_l}), 64'(2'b10));
        @(negedge clk);
        chk("bp no stray op", 64'({in_ready_l, out_valid_l}), 64'(2'b10));

        // Reset during the multiplier iterations
        A         = 32'h3FC00000;
        B         = 32'h40000000;
        opcode    = 2'b10;
        drv_valid = 1'b1;
        @(negedge clk);
        drv_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("pre-reset busy", 64'({in_ready_l, out_valid_l}), 64'(2'b00));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid-mul rst state", 64'({in_ready_l, out_valid_l, outp_l, nv_l, of_l, uf_l}),
            64'({1'b1, 1'b0, 32'h00000000, 3'b000}));
        repeat (30) @(negedge clk);
        chk("mid-mul op discarded", 64'(out_valid_l), 64'd0);
        run_vec(vecs[c_NV-1]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
